// File: rtl/lcd_hd44780_tx_pkg.sv
// Shared types and constants for the HD44780 LCD transmitter: FSM states,
// command bytes, the power-on init ROM and timer load helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_EXEC_WAIT
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY_INC = 8'h06;

  localparam int INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    LCD_CMD_FUNC_8B2L, LCD_CMD_FUNC_8B2L, LCD_CMD_FUNC_8B2L,
    LCD_CMD_DISP_ON, LCD_CMD_CLEAR, LCD_CMD_ENTRY_INC
  };

  // A state lasting n cycles loads n-1; zero-length states still last one cycle.
  function automatic logic [19:0] cyc_load(input int unsigned n);
    if (n <= 1) return 20'd0;
    return 20'(n - 1);
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_hd44780_tx_if.sv
// CPU-side byte channel into the LCD transmitter, plus the init status flag.
interface lcd_hd44780_tx_if;
  // A byte transfers on a clock edge where tx_valid and tx_ready are both 1;
  // tx_rs/tx_data are sampled on that edge. tx_valid without tx_ready is dropped,
  // the sender is not required to hold it, and nothing is buffered.
  logic       tx_valid;
  logic       tx_rs;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       init_done;

  modport master (output tx_valid, tx_rs, tx_data, input tx_ready, init_done);
  modport slave  (input tx_valid, tx_rs, tx_data, output tx_ready, init_done);
endinterface

// File: rtl/lcd_hd44780_tx_timer.sv
// Loadable 20-bit down-counter that paces every LCD FSM state.
module lcd_timer (
  input  logic        clk,
  input  logic        load,
  input  logic [19:0] load_val,
  input  logic        tick,
  output logic        done
);

  logic [19:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (tick && (count != 20'd0)) begin
      count <= count - 20'd1;
    end
  end

  assign done = (count == 20'd0);

endmodule

// File: rtl/lcd_hd44780_tx.sv
// Write-only HD44780 transmitter: bus timing FSM with optional power-on init
// sequence, enabled by defining LCD_INIT_SEQ_EN.
module lcd_hd44780_tx
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EN_CYC        = 25,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned CMD_WAIT_CYC  = 2000,
  parameter int unsigned LONG_WAIT_CYC = 82000,
  parameter int unsigned PWR_WAIT_CYC  = 750000,
  parameter logic        BLON_VAL      = 1'b1
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  lcd_hd44780_tx_if.slave bus,
  output logic [7:0]    LCD_DATA,
  output logic          LCD_RW,
  output logic          LCD_RS,
  output logic          LCD_EN,
  output logic          LCD_ON,
  output logic          LCD_BLON,
  output lcd_state_t    dbg_state
);

`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_t RESET_STATE = ST_PWR_WAIT;
  logic [2:0] init_idx;
  logic       init_pending;
  assign init_pending = (init_idx != 3'(INIT_LEN));
`else
  localparam lcd_state_t RESET_STATE = ST_IDLE;
`endif

  lcd_state_t  state, state_next;
  logic        tx_ready_r, init_done_r, en_r, rs_r;
  logic [7:0]  data_r;
  logic        accept, tmr_load, tmr_done;
  logic [19:0] tmr_load_val;

  function automatic int unsigned state_cycles(input lcd_state_t s, input logic long_wait);
    case (s)
      ST_PWR_WAIT:  return PWR_WAIT_CYC;
      ST_INIT:      return 1;
      ST_SETUP:     return SETUP_CYC;
      ST_EN_HI:     return EN_CYC;
      ST_HOLD:      return HOLD_CYC;
      ST_EXEC_WAIT: return long_wait ? LONG_WAIT_CYC : CMD_WAIT_CYC;
      default:      return 0;
    endcase
  endfunction

  assign accept = bus.tx_valid && tx_ready_r;

  // Reload on every state change; during reset preload the first state's count.
  assign tmr_load     = reset || (state_next != state);
  assign tmr_load_val = reset ? cyc_load(state_cycles(RESET_STATE, 1'b0))
                              : cyc_load(state_cycles(state_next, is_long_cmd(rs_r, data_r)));

  lcd_timer u_timer (
    .clk      (CLOCK_50),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (1'b1),
    .done     (tmr_done)
  );

  always_comb begin
    state_next = state;
    case (state)
`ifdef LCD_INIT_SEQ_EN
      ST_PWR_WAIT:  if (tmr_done) state_next = ST_INIT;
      ST_INIT:      if (tmr_done) state_next = ST_SETUP;
`endif
      ST_IDLE:      if (accept)   state_next = ST_SETUP;
      ST_SETUP:     if (tmr_done) state_next = ST_EN_HI;
      ST_EN_HI:     if (tmr_done) state_next = ST_HOLD;
      ST_HOLD:      if (tmr_done) state_next = ST_EXEC_WAIT;
      ST_EXEC_WAIT: begin
        if (tmr_done) begin
`ifdef LCD_INIT_SEQ_EN
          state_next = init_pending ? ST_INIT : ST_IDLE;
`else
          state_next = ST_IDLE;
`endif
        end
      end
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from state_next so they line up with the state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= RESET_STATE;
      tx_ready_r  <= 1'b0;
      init_done_r <= 1'b0;
      en_r        <= 1'b0;
      rs_r        <= 1'b0;
      data_r      <= 8'd0;
`ifdef LCD_INIT_SEQ_EN
      init_idx    <= 3'd0;
`endif
    end else begin
      state       <= state_next;
      tx_ready_r  <= (state_next == ST_IDLE);
      init_done_r <= init_done_r || (state_next == ST_IDLE);
      en_r        <= (state_next == ST_EN_HI);
      if (accept) begin
        rs_r   <= bus.tx_rs;
        data_r <= bus.tx_data;
      end
`ifdef LCD_INIT_SEQ_EN
      if ((state == ST_INIT) && tmr_done) begin
        rs_r     <= 1'b0;
        data_r   <= INIT_ROM[init_idx];
        init_idx <= init_idx + 3'd1;
      end
`endif
    end
  end

  assign bus.tx_ready  = tx_ready_r;
  assign bus.init_done = init_done_r;
  assign LCD_DATA      = data_r;
  assign LCD_RS        = rs_r;
  assign LCD_EN        = en_r;
  assign LCD_RW        = 1'b0;
  assign LCD_ON        = 1'b1;
  assign LCD_BLON      = BLON_VAL;
  assign dbg_state     = state;

endmodule

// File: tb/tb_lcd_hd44780_tx.sv
// Bench for lcd_hd44780_tx: directed and random byte writes checked against a
// timing model, a strobe scoreboard, handshake streaming and mid-strobe reset.
module tb_lcd_hd44780_tx;
  import lcd_pkg::*;

  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 1;
  localparam int CW = 5;
  localparam int LW = 12;
  localparam int PW = 10;

  // clock/reset
  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #10 CLOCK_50 = ~CLOCK_50;

  lcd_hd44780_tx_if bus ();
  logic [7:0] LCD_DATA;
  logic       LCD_RW, LCD_RS, LCD_EN, LCD_ON, LCD_BLON;
  lcd_state_t dbg_state;

  lcd_hd44780_tx #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
    .CMD_WAIT_CYC(CW), .LONG_WAIT_CYC(LW), .PWR_WAIT_CYC(PW), .BLON_VAL(1'b1)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .bus       (bus),
    .LCD_DATA  (LCD_DATA),
    .LCD_RW    (LCD_RW),
    .LCD_RS    (LCD_RS),
    .LCD_EN    (LCD_EN),
    .LCD_ON    (LCD_ON),
    .LCD_BLON  (LCD_BLON),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  bit rw_bad = 1'b0;
  bit on_bad = 1'b0;
  logic [7:0] init_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  logic [7:0] specials [8]   = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h80, 8'h41, 8'hFF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic int exp_wait(input logic rs, input logic [7:0] d);
    if (!rs && d >= 8'd1 && d <= 8'd3) return LW;
    return CW;
  endfunction

  function automatic int exp_latency(input logic rs, input logic [7:0] d);
    return 1 + S + E + H + exp_wait(rs, d);
  endfunction

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // strobe monitor / scoreboard
  int         en_run = 0;
  logic [8:0] rise_val = '0;
  always @(posedge CLOCK_50) begin
    #2;
    if (LCD_RW !== 1'b0) rw_bad = 1'b1;
    if (LCD_ON !== 1'b1) on_bad = 1'b1;
    if (LCD_EN === 1'b1) begin
      if (en_run == 0) rise_val = {LCD_RS, LCD_DATA};
      en_run++;
    end else if (en_run != 0) begin
      if (reset) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        check("en_width", 32'(en_run), 32'(E));
        check("hold_stable", 32'({LCD_RS, LCD_DATA}), 32'(rise_val));
        if (exp_q.size() == 0) check("unexpected_strobe", 32'(1), 32'(0));
        else check("strobe_byte", 32'({LCD_RS, LCD_DATA}), 32'(exp_q.pop_front()));
      end
      en_run = 0;
    end
  end

  // driver tasks
  task automatic wait_ready();
    for (int i = 0; i < 400 && !bus.tx_ready; i++) step();
    if (!bus.tx_ready) check("wait_ready_timeout", 32'(0), 32'(1));
  endtask

  task automatic after_reset();
`ifdef LCD_INIT_SEQ_EN
    int n = 0;
    int expn = PW;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b0, init_bytes[i]});
      expn += 1 + S + E + H + exp_wait(1'b0, init_bytes[i]);
    end
    while (!bus.init_done && n < 1000) begin
      if (bus.tx_ready) check("ready_during_init", 32'(1), 32'(0));
      step();
      n++;
    end
    check("init_cycles", 32'(n), 32'(expn));
    check("ready_at_init_done", 32'(bus.tx_ready), 32'(1));
`else
    step();
    check("ready_after_rst", 32'(bus.tx_ready), 32'(1));
    check("init_done_after_rst", 32'(bus.init_done), 32'(1));
    check("idle_after_rst", 32'(dbg_state), 32'(ST_IDLE));
`endif
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] d);
    int n;
    int en_first = 0;
    int en_last  = 0;
    wait_ready();
    exp_q.push_back({rs, d});
    bus.tx_valid = 1'b1;
    bus.tx_rs    = rs;
    bus.tx_data  = d;
    step();
    bus.tx_valid = 1'b0;
    bus.tx_rs    = 1'($urandom_range(0, 1));
    bus.tx_data  = 8'($urandom);
    n = 1;
    check("rsdata_at_1", 32'({LCD_RS, LCD_DATA}), 32'({rs, d}));
    check("ready_low_at_1", 32'(bus.tx_ready), 32'(0));
    while (!bus.tx_ready && n < 200) begin
      if (LCD_EN) begin
        if (en_first == 0) en_first = n;
        en_last = n;
      end
      step();
      n++;
    end
    check("latency", 32'(n), 32'(exp_latency(rs, d)));
    check("en_rise", 32'(en_first), 32'(1 + S));
    check("en_last", 32'(en_last), 32'(S + E));
  endtask

  initial begin
    int accepts = 0;
    bus.tx_valid = 1'b0;
    bus.tx_rs    = 1'b0;
    bus.tx_data  = 8'd0;
    reset        = 1'b1;
    repeat (3) step();
    check("rst_ready", 32'(bus.tx_ready), 32'(0));
    check("rst_init_done", 32'(bus.init_done), 32'(0));
    check("rst_data", 32'(LCD_DATA), 32'(0));
    check("rst_rs", 32'(LCD_RS), 32'(0));
    check("rst_en", 32'(LCD_EN), 32'(0));
    check("rst_rw", 32'(LCD_RW), 32'(0));
    check("rst_on", 32'(LCD_ON), 32'(1));
    reset = 1'b0;
    after_reset();

    // directed boundaries
    send_byte(1'b1, 8'h41);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h80);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h03);
    send_byte(1'b0, 8'h04);
    send_byte(1'b1, 8'h02);

    // random bytes, biased toward wait-selection edges
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      if ($urandom_range(0, 1) == 1) d = specials[$urandom_range(0, 7)];
      else d = 8'($urandom);
      send_byte(1'($urandom_range(0, 1)), d);
    end

    // tx_valid held high with changing data
    wait_ready();
    bus.tx_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      bus.tx_rs   = 1'($urandom_range(0, 1));
      bus.tx_data = 8'($urandom);
      if (bus.tx_ready) begin
        exp_q.push_back({bus.tx_rs, bus.tx_data});
        accepts++;
      end
      step();
    end
    bus.tx_valid = 1'b0;
    check("stream_accepts", 32'(accepts >= 4), 32'(1));

    // reset while EN is high
    wait_ready();
    exp_q.push_back({1'b1, 8'h55});
    bus.tx_valid = 1'b1;
    bus.tx_rs    = 1'b1;
    bus.tx_data  = 8'h55;
    step();
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 50 && !LCD_EN; i++) step();
    check("en_seen_before_rst", 32'(LCD_EN), 32'(1));
    reset = 1'b1;
    step();
    check("midrst_en_low", 32'(LCD_EN), 32'(0));
    check("midrst_ready_low", 32'(bus.tx_ready), 32'(0));
    check("midrst_init_done_low", 32'(bus.init_done), 32'(0));
`ifdef LCD_INIT_SEQ_EN
    check("midrst_state", 32'(dbg_state), 32'(ST_PWR_WAIT));
`else
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
`endif
    step();
    reset = 1'b0;
    after_reset();
    send_byte(1'b1, 8'h7A);

    for (int i = 0; i < 400 && !(bus.tx_ready && exp_q.size() == 0); i++) step();
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("rw_always_low", 32'(rw_bad), 32'(0));
    check("on_always_high", 32'(on_bad), 32'(0));
    check("blon", 32'(LCD_BLON), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
